shift_sequencer: RTL
====================

Name: shift_sequencer

Overview:
- Multi-cycle sequencer for register-specified shifts: ARM-style LSL/LSR/ASR/ROR by an 8-bit amount taken from a register's low byte.
- The single-cycle pre-ALU shifter handles only immediate shift amounts of 0-31; this block covers amounts 0-255.
- Works iteratively, shifting by at most STEP bits per cycle under a start/busy/done handshake.
- Sits beside the pre-ALU shifter; the control unit stalls on busy.

Parameters:
- WIDTH, 32: datapath width; must be a power of two, at most 128.
- STEP, 4: maximum bits shifted per cycle; 1 <= STEP < WIDTH.
- AMT_W, 8: width of the shift-amount input.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only while busy=0.
- sh_type  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
- src  input  WIDTH  operand to shift.
- amount  input  AMT_W  unsigned shift amount.
- busy  output  1  high from the accepted start until done.
- done  output  1  one-cycle completion pulse.
- result  output  WIDTH  shifted value.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, result=0, internal count=0. An operation in progress is abandoned with no done pulse.
- States:
  - IDLE: start=1 at an edge latches src into the working register (drives result), computes eff, sets count=eff. Goes to RUN if eff>0, else DONE.
  - RUN: each edge shifts by s=min(count,STEP) and sets count-=s. Goes to DONE when the step leaves count=0.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- busy=1 in RUN and DONE-entry... precisely: busy=1 whenever state=RUN, and 0 in IDLE and DONE.
- start while busy=1 is ignored (not queued). start in the DONE cycle is ignored.
- Effective amount (eff):
  - LSL/LSR/ASR: eff=min(amount, WIDTH).
  - ROR: eff=amount mod WIDTH.
- Per-step semantics:
  - LSL and LSR fill with 0.
  - ASR fills with src[WIDTH-1].
  - ROR rotates right.
- Saturation results: LSL/LSR with amount>=WIDTH give 0. ASR with amount>=WIDTH gives all copies of the sign bit.
- ROR with amount a nonzero multiple of WIDTH gives result=src (eff=0).
- Latency: done is high in the cycle after the (1+ceil(eff/STEP))-th edge counted from the accepting edge. eff=0 gives 1 cycle.
- result is valid from the done cycle and held until the next accepted start reloads it. Mid-operation values are unspecified to consumers.

Optional Feature:
- Macro: SHIFT_CARRY_EN.
- Defined: adds ports carry_in (input, 1) and carry_out (output, 1, reset 0). carry_out is valid with done and held alongside result. Rules:
  - amount=0: carry_out=carry_in.
  - Otherwise: carry_out = last bit shifted out of the final step.
  - LSL with amount=WIDTH: src[0]. LSR with amount=WIDTH: src[WIDTH-1].
  - LSL/LSR with amount>WIDTH: 0.
  - ASR with amount>=WIDTH: src[WIDTH-1].
  - ROR with eff=0 and amount≠0: src[WIDTH-1].
- Not defined: those ports are absent and no carry logic is built.

Decomposition:
- Package shift_pkg holds:
  - typedef enum logic [1:0] shift_t {SH_LSL, SH_LSR, SH_ASR, SH_ROR};
  - typedef enum state_t {S_IDLE, S_RUN, S_DONE}.
- Sub-module shift_step: combinational; inputs value, sh_type, s (0..STEP); outputs shifted value and the last bit out. Instantiated once per sequencer.

Test Plan (WIDTH=32, STEP=4, SHIFT_CARRY_EN defined):
- LSL, src=0x0000_00F1, amount=4 -> result 0x0000_0F10, carry_out 0, done 2 cycles after start.
- ASR, src=0x8000_0000, amount=40 -> result 0xFFFF_FFFF, carry_out 1, latency 9, busy high throughout RUN.
- ROR, src=0x1234_5678, amount=36 -> result 0x8123_4567, carry_out 1, latency 2. Repeat with amount=64 -> result 0x1234_5678, carry_out 0, latency 1.
- LSR, src=0x8000_0001:
  - amount=32 -> result 0, carry_out 1.
  - amount=33 -> result 0, carry_out 0.
  - amount=0 with carry_in=1 -> result 0x8000_0001, carry_out 1, latency 1.
- Busy and reset behaviour:
  - Pulse start again during busy with different operands -> ignored; first result is unchanged and exactly one done pulse occurs.
  - Assert reset mid-RUN -> busy, done and result go to 0 immediately and there is no done pulse.
  - After reset, a new start completes normally.

Source files
------------

// File: rtl/shift_pkg.sv
// ============================================================================
// Module      : shift_pkg
// Description : Shared types for the register-specified shift sequencer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package shift_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

`default_nettype wire

// File: rtl/shift_step.sv
// ============================================================================
// Module      : shift_step
// Description : Combinational single-step shifter (0..STEP bits) used by the
//               iterative sequencer. SHIFT_CARRY_EN adds the last-bit-out port.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int SW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] value,
  input  shift_t           sh_type,
  input  logic [SW-1:0]    s,
  output logic [WIDTH-1:0] shifted
`ifdef SHIFT_CARRY_EN
  ,
  output logic             last_out
`endif
);

  always_comb begin
    shifted = value;
    case (sh_type)
      SH_LSL:  shifted = value << s;
      SH_LSR:  shifted = value >> s;
      SH_ASR:  shifted = $unsigned($signed(value) >>> s);
      SH_ROR:  shifted = (value >> s) | (value << (WIDTH - int'(s)));
      default: shifted = value;
    endcase
  end

`ifdef SHIFT_CARRY_EN
  localparam int IW = $clog2(WIDTH);

  logic [IW-1:0] left_idx;
  logic [IW-1:0] right_idx;

  // Left shifts lose bit WIDTH-s last; right shifts and rotates lose bit s-1.
  always_comb begin
    left_idx  = IW'(WIDTH - int'(s));
    right_idx = IW'(int'(s) - 1);
    last_out  = 1'b0;
    if (s != '0) begin
      last_out = (sh_type == SH_LSL) ? value[left_idx] : value[right_idx];
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/shift_sequencer.sv
// ============================================================================
// Module      : shift_sequencer
// Description : Iterative LSL/LSR/ASR/ROR by an AMT_W-bit amount, at most STEP
//               bits per cycle, start/busy/done handshake.
//               Optional macro SHIFT_CARRY_EN adds carry_in/carry_out.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int AMT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       sh_type,
  input  logic [WIDTH-1:0] src,
  input  logic [AMT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
`ifdef SHIFT_CARRY_EN
  ,
  input  logic             carry_in,
  output logic             carry_out
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int SW    = $clog2(STEP + 1);
  localparam logic [CNT_W-1:0] STEP_CNT = CNT_W'(STEP);

  state_t             state_q, state_d;
  shift_t             type_q, type_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   eff;
  logic [SW-1:0]      step_s;
  logic [WIDTH-1:0]   step_out;

  // ROR wraps modulo WIDTH; the linear shifts saturate at WIDTH.
  always_comb begin
    if (shift_t'(sh_type) == SH_ROR) begin
      eff = CNT_W'(int'(amount) % WIDTH);
    end else if (int'(amount) >= WIDTH) begin
      eff = CNT_W'(WIDTH);
    end else begin
      eff = CNT_W'(amount);
    end
  end

  assign step_s = (count_q > STEP_CNT) ? SW'(STEP) : SW'(count_q);

`ifdef SHIFT_CARRY_EN
  logic step_last;
  logic carry_q, carry_d;
  logic zero_q, zero_d;

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .SW    (SW)
  ) u_step (
    .value    (work_q),
    .sh_type  (type_q),
    .s        (step_s),
    .shifted  (step_out),
    .last_out (step_last)
  );
`else
  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .SW    (SW)
  ) u_step (
    .value    (work_q),
    .sh_type  (type_q),
    .s        (step_s),
    .shifted  (step_out)
  );
`endif

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    work_d  = work_q;
    count_d = count_q;
`ifdef SHIFT_CARRY_EN
    carry_d = carry_q;
    zero_d  = zero_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          work_d  = src;
          type_d  = shift_t'(sh_type);
          count_d = eff;
          state_d = (eff != '0) ? S_RUN : S_DONE;
`ifdef SHIFT_CARRY_EN
          // Covers amount=0 and ROR by a multiple of WIDTH; RUN overwrites it.
          carry_d = (amount == '0) ? carry_in : src[WIDTH-1];
          zero_d  = ((shift_t'(sh_type) == SH_LSL) || (shift_t'(sh_type) == SH_LSR))
                    && (int'(amount) > WIDTH);
`endif
        end
      end
      S_RUN: begin
        work_d  = step_out;
        count_d = count_q - CNT_W'(step_s);
`ifdef SHIFT_CARRY_EN
        carry_d = zero_q ? 1'b0 : step_last;
`endif
        if (count_d == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      type_q  <= SH_LSL;
      work_q  <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SHIFT_CARRY_EN
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      work_q  <= work_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SHIFT_CARRY_EN
      carry_q <= carry_d;
      zero_q  <= zero_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = work_q;
`ifdef SHIFT_CARRY_EN
  assign carry_out = carry_q;
`endif

endmodule

`default_nettype wire
